// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - handshake/bus bundle between frame_sequencer and its neighbours
//
// Purpose: groups the client-FIFO read side, the line tick/enable controls and
// the presented-position/payload outputs of frame_sequencer into one interface.
//
// Signals:
//   enable          level, start framing / request stop
//   tick            line byte-slot strobe
//   fifo_empty      client FIFO empty
//   fifo_data[7:0]  client FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en      client FIFO read strobe
//   row_cnt[1:0]    row of presented byte
//   col_cnt[10:0]   column of presented byte
//   pyld_data[7:0]  payload byte (0 when not valid)
//   pyld_data_valid payload byte valid
//   step            one-cycle pulse, outputs moved to a new position
//   frame_start     pulse with step at position (0,0)
//   underrun        pulse with step when a payload slot had no data
//   underrun_cnt    saturating underrun count
//   busy            sequencer not idle
//
// Modports: master = environment side (drives controls and FIFO data),
//           slave  = frame_sequencer side.

interface frame_sequencer_if #(
  parameter int UNDR_W = 16
);
  logic              enable;
  logic              tick;
  logic              fifo_empty;
  logic [7:0]        fifo_data;
  logic              fifo_rd_en;
  logic [1:0]        row_cnt;
  logic [10:0]       col_cnt;
  logic [7:0]        pyld_data;
  logic              pyld_data_valid;
  logic              step;
  logic              frame_start;
  logic              underrun;
  logic [UNDR_W-1:0] underrun_cnt;
  logic              busy;

  modport master (
    output enable, tick, fifo_empty, fifo_data,
    input  fifo_rd_en, row_cnt, col_cnt, pyld_data, pyld_data_valid,
    input  step, frame_start, underrun, underrun_cnt, busy
  );

  modport slave (
    input  enable, tick, fifo_empty, fifo_data,
    output fifo_rd_en, row_cnt, col_cnt, pyld_data, pyld_data_valid,
    output step, frame_start, underrun, underrun_cnt, busy
  );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - row/column sequencer and payload puller for a 4-row line frame
//
// Purpose: walks every byte position of a NUM_ROWS x NUM_COLS frame, one
// position per accepted line tick, reads the client FIFO only in payload
// columns, and presents position plus payload one cycle after the tick.
// Starts framing on enable; on enable low it finishes the current frame
// before going idle. Counts payload underruns with saturation.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  frame_sequencer_if.slave (controls, FIFO read side, presented outputs)

module frame_sequencer #(
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 1041,
  parameter int OH_COLS   = 16,
  parameter int STUFF_COL = 1040,
  parameter int UNDR_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  frame_sequencer_if.slave bus
);

  localparam int ROW_W = 2;
  localparam int COL_W = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] COL_PY_LO  = COL_W'(OH_COLS);
  localparam logic [COL_W-1:0] COL_STUFF  = COL_W'(STUFF_COL);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;

  logic              active;
  logic              accepted;
  logic              is_payload;
  logic              rd_issue;
  logic              at_col_end;
  logic              at_last;

  // Presented (stage-1) registers
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              valid_q;
  logic              step_q;
  logic              frame_start_q;
  logic              underrun_q;
  logic [7:0]        data_hold;
  logic [7:0]        pyld_now;
  logic [UNDR_W-1:0] undr_cnt;

  assign active     = (state == ST_RUN) || (state == ST_FINISH);
  assign accepted   = active && bus.tick;
  assign is_payload = (col >= COL_PY_LO) && (col < COL_STUFF);
  assign at_col_end = (col == COL_LAST);
  assign at_last    = at_col_end && (row == ROW_LAST);

  // Gated by rst so no read strobe escapes while reset is being applied.
  assign rd_issue       = accepted && is_payload && !bus.fifo_empty && !rst;
  assign bus.fifo_rd_en = rd_issue;

  // Leaving RUN/FINISH happens only on the tick that processes the final
  // position with enable low, so a frame is never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.enable) state_nxt = ST_RUN;
      end
      ST_RUN, ST_FINISH: begin
        if (bus.enable)              state_nxt = ST_RUN;
        else if (accepted && at_last) state_nxt = ST_IDLE;
        else                          state_nxt = ST_FINISH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage 0: position counter. The final position wraps to (0,0), so an idle
  // sequencer always restarts at the frame origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state == ST_IDLE) begin
      row <= '0;
      col <= '0;
    end else if (accepted) begin
      if (at_col_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1: the position of the accepted tick is registered at the tick's
  // edge, so it appears together with step on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q         <= '0;
      col_q         <= '0;
      valid_q       <= 1'b0;
      step_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      undr_cnt      <= '0;
    end else begin
      step_q        <= accepted;
      frame_start_q <= accepted && (row == '0) && (col == '0);
      underrun_q    <= accepted && is_payload && !rd_issue;
      if (accepted) begin
        row_q   <= row;
        col_q   <= col;
        valid_q <= rd_issue;
      end
      // Counted at the same edge that raises underrun so both are seen together.
      if (accepted && is_payload && !rd_issue && (undr_cnt != {UNDR_W{1'b1}})) begin
        undr_cnt <= undr_cnt + 1'b1;
      end
    end
  end

  // FIFO data only arrives in the step cycle, so it is passed through then and
  // captured into data_hold to keep the byte stable until the next step.
  assign pyld_now = valid_q ? bus.fifo_data : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_hold <= 8'd0;
    end else if (step_q) begin
      data_hold <= pyld_now;
    end
  end

  assign bus.row_cnt         = row_q;
  assign bus.col_cnt         = col_q;
  assign bus.pyld_data_valid = valid_q;
  assign bus.pyld_data       = step_q ? pyld_now : data_hold;
  assign bus.step            = step_q;
  assign bus.frame_start     = frame_start_q;
  assign bus.underrun        = underrun_q;
  assign bus.underrun_cnt    = undr_cnt;
  assign bus.busy            = active;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer

module tb_frame_sequencer;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 1041;
  localparam int FRAME    = NUM_ROWS * NUM_COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_sequencer_if #(.UNDR_W(16)) bus();

  frame_sequencer #(.UNDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Client FIFO: returns an incrementing byte the cycle after each read.
  int fptr = 0;
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data <= 8'(fptr);
      fptr          <= fptr + 1;
    end
  end

  // Reference model: linear byte index within the frame plus an active flag.
  int         idx;
  bit         active;
  int         reads = 0;
  int         und_total;
  int         rd_total = 0;
  logic [1:0]  e_row;
  logic [10:0] e_col;
  logic [7:0]  e_data;
  logic        e_valid, e_step, e_fs, e_und;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    idx = 0; active = 0; und_total = 0;
    e_row = '0; e_col = '0; e_data = '0;
    e_valid = 0; e_step = 0; e_fs = 0; e_und = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_step"},  {31'd0, bus.step}, {31'd0, e_step});
    check({pfx, "_fs"},    {31'd0, bus.frame_start}, {31'd0, e_fs});
    check({pfx, "_und"},   {31'd0, bus.underrun}, {31'd0, e_und});
    check({pfx, "_row"},   {30'd0, bus.row_cnt}, {30'd0, e_row});
    check({pfx, "_col"},   {21'd0, bus.col_cnt}, {21'd0, e_col});
    check({pfx, "_valid"}, {31'd0, bus.pyld_data_valid}, {31'd0, e_valid});
    check({pfx, "_data"},  {24'd0, bus.pyld_data}, {24'd0, e_data});
    check({pfx, "_ucnt"},  {16'd0, bus.underrun_cnt}, (und_total > 65535) ? 32'd65535 : 32'(und_total));
    check({pfx, "_busy"},  {31'd0, bus.busy}, {31'd0, active});
  endtask

  // One clock: drive inputs at the falling edge, check the combinational read
  // strobe, predict, then check registered outputs at the next falling edge.
  task automatic step_cycle(input logic en, input logic tk, input logic emp);
    int r, c;
    bit pay, rd;
    bus.enable = en; bus.tick = tk; bus.fifo_empty = emp;
    #1;
    r   = idx / NUM_COLS;
    c   = idx % NUM_COLS;
    pay = (c >= 16) && (c <= 1039);
    rd  = active && tk && pay && !emp;
    check("rd_en", {31'd0, bus.fifo_rd_en}, {31'd0, rd});
    e_step = 0; e_fs = 0; e_und = 0;
    if (active && tk) begin
      e_step  = 1;
      e_row   = 2'(r);
      e_col   = 11'(c);
      e_valid = rd;
      e_fs    = (idx == 0);
      e_und   = pay && !rd;
      if (rd) begin
        e_data = 8'(reads);
        reads++;
        rd_total++;
      end else begin
        e_data = 8'd0;
      end
      if (e_und) und_total++;
      if (!en && idx == FRAME - 1) active = 0;
      idx = (idx + 1) % FRAME;
    end else if (!active && en) begin
      active = 1;
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  initial begin
    int base;
    int guard;
    bus.enable = 0; bus.tick = 0; bus.fifo_empty = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 0;

    // Full frame, tick every cycle, FIFO never empty.
    step_cycle(1, 0, 0);
    base = rd_total;
    for (int i = 0; i < FRAME; i++) step_cycle(1, 1, 0);
    check("frame_reads", 32'(rd_total - base), 32'd4096);

    // Next frame: FIFO empty for cols 100..109 of row 2.
    while (idx != 2 * NUM_COLS + 110) begin
      step_cycle(1, 1, (idx / NUM_COLS == 2) && (idx % NUM_COLS >= 100) && (idx % NUM_COLS <= 109));
    end
    check("undr_cnt10", {16'd0, bus.underrun_cnt}, 32'd10);

    // Tick every third cycle with random empties.
    for (int i = 0; i < 600; i++) step_cycle(1, (i % 3) == 0, $urandom_range(7) == 0);

    // Drop enable at (1,500); the frame must run out to (3,1040).
    guard = 0;
    while (idx != NUM_COLS + 500 && guard < 8000) begin
      step_cycle(1, $urandom_range(3) != 0, $urandom_range(15) == 0);
      guard++;
    end
    guard = 0;
    while (active && guard < 6000) begin
      step_cycle(0, $urandom_range(3) != 0, $urandom_range(15) == 0);
      guard++;
    end
    check("stop_bound", 32'(guard < 6000), 32'd1);
    check("stop_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 20; i++) step_cycle(0, 1, 0);

    // Re-enable restarts at (0,0); run to (2,700) then reset with rd_en high.
    step_cycle(1, 0, 0);
    guard = 0;
    while (idx != 2 * NUM_COLS + 700 && guard < 5000) begin
      step_cycle(1, 1, 0);
      guard++;
    end
    bus.enable = 1; bus.tick = 1; bus.fifo_empty = 0;
    #1;
    check("rd_pre_rst", {31'd0, bus.fifo_rd_en}, 32'd1);
    rst = 1;
    #1;
    model_reset();
    check("rd_in_rst", {31'd0, bus.fifo_rd_en}, 32'd0);
    check_outputs("async_rst");
    @(negedge clk);
    rst = 0;

    // Saturate the underrun counter: FIFO permanently empty.
    step_cycle(1, 0, 1);
    guard = 0;
    while (und_total < 65541 && guard < 80000) begin
      step_cycle(1, 1, 1);
      guard++;
    end
    check("undr_sat", {16'd0, bus.underrun_cnt}, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Sequences the sender-side mapper by generating the row/column position for every byte of a 4-row line frame.
- Pulls payload bytes from the client FIFO only in payload columns and presents position plus payload to the frame controller, one byte per accepted line tick.
- Owns frame start/stop on enable, and detects and counts payload underruns.

Parameters:
- NUM_ROWS, 4, rows per frame (fits 2-bit row count).
- NUM_COLS, 1041, columns per row, 0..1040 (fits 11-bit column count).
- OH_COLS, 16, overhead columns 0..OH_COLS-1 per row (no payload read).
- STUFF_COL, 1040, fixed-stuff column (no payload read).
- UNDR_W, 16, underrun counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  level; start framing / request stop.
- i_tick  in  1  line byte-slot strobe; one byte position per accepted tick.
- i_fifo_empty  in  1  client FIFO empty.
- i_fifo_data  in  8  client FIFO read data, valid the cycle after o_fifo_rd_en.
- o_fifo_rd_en  out  1  client FIFO read strobe.
- o_row_cnt  out  2  row of presented byte.
- o_col_cnt  out  11  column of presented byte.
- o_pyld_data  out  8  payload byte (0 when not valid).
- o_pyld_data_valid  out  1  payload byte valid.
- o_step  out  1  one-cycle pulse: outputs updated to a new position this cycle.
- o_frame_start  out  1  pulse with o_step when presented position is row 0, col 0.
- o_underrun  out  1  pulse with o_step when a payload slot had no data.
- o_underrun_cnt  out  UNDR_W  saturating underrun count.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, i_rst=1): state IDLE; internal row/col = 0; all outputs 0.
- States: IDLE, RUN, FINISH.
  - IDLE -> RUN when i_enable=1. Next accepted tick processes position (0,0).
  - RUN -> FINISH when i_enable=0 at any point.
  - FINISH behaves exactly as RUN until the last position (NUM_ROWS-1, NUM_COLS-1) is processed, then goes to IDLE. Frames are never truncated.
  - FINISH -> RUN if i_enable returns to 1 before that last position.
- Accepted tick: i_tick=1 in RUN or FINISH. Ticks in IDLE are ignored.
- Stage 0, on the accepted-tick cycle:
  - Payload slot = col in [OH_COLS, STUFF_COL-1], i.e. 16..1039.
  - o_fifo_rd_en = accepted tick & payload slot & !i_fifo_empty (combinational). Never asserted outside payload slots.
  - Advance col. At NUM_COLS-1, col wraps to 0 and row increments; at NUM_ROWS-1, row wraps to 0.
  - Capture pending {row, col, is_payload, rd_issued}.
- Stage 1, the cycle after an accepted tick:
  - Register o_row_cnt/o_col_cnt from the captured position.
  - o_pyld_data_valid = rd_issued; o_pyld_data = rd_issued ? i_fifo_data : 0.
  - o_step = 1; o_frame_start = (row==0 & col==0).
  - o_underrun = is_payload & !rd_issued.
  - Outputs hold until the next o_step; pulses last exactly one cycle.
- Latency: exactly 1 cycle, accepted tick -> o_step. Back-to-back ticks give o_step every cycle.
- o_underrun_cnt increments by 1 per o_underrun and saturates at all-ones.
- Transition to IDLE:
  - Takes effect the cycle after the last accepted tick; that tick's stage-1 update still occurs.
  - Internal position returns to (0,0).
  - Outputs hold their last values, except pulses, which clear.
- Reset mid-frame: immediate return to reset values. No FIFO read is issued in the reset cycle.

Test Plan:
- Reset, enable=1, tick every cycle, FIFO never empty with incrementing data -> first o_step shows (0,0) with o_frame_start=1.
  - rd_en first at col 16; 4096 reads per frame (4x1024).
  - Cols 0-15 and 1040 have valid=0, data=0.
  - After (3,1040), the next o_step shows (0,0) with frame_start=1.
- Tick every 3rd cycle -> o_step exactly 1 cycle after each tick; outputs hold between steps; data order preserved; no rd_en without a tick.
- FIFO empty for cols 100-109 of row 2 -> 10 o_underrun pulses, o_underrun_cnt=10, valid=0, data=0 at those positions, no rd_en for those slots.
- Drop enable at (1,500) -> framing continues to (3,1040), then o_busy=0. Further ticks give no o_step and no rd_en. Re-enable restarts at (0,0).
- Assert i_rst at (2,700) with rd_en high -> all outputs 0 asynchronously, state IDLE. After release and enable, the frame restarts at (0,0).
- Force 2^16+5 underruns -> o_underrun_cnt saturates at 0xFFFF.
